// File: rtl/fan_sched_pkg.sv
// Shared state encodings, default durations and counter widths for the fan mode scheduler.
package fan_sched_pkg;

  typedef enum logic [2:0] {
    ST_STANDBY    = 3'b000,
    ST_MODE1      = 3'b001,
    ST_MODE2      = 3'b010,
    ST_MODE3      = 3'b011,
    ST_SELF_CLEAN = 3'b100,
    ST_EXIT_DELAY = 3'b101
  } fan_state_e;

  localparam int unsigned DEF_HURRICANE_SEC = 60;
  localparam int unsigned DEF_EXIT_SEC      = 60;
  localparam int unsigned DEF_CLEAN_SEC     = 180;
  localparam int unsigned DEF_REMIND_SEC    = 36000;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned ACC_W = 16;

endpackage

// File: rtl/fan_mode_scheduler_if.sv
// Button/tick inputs and mode/status outputs of the fan mode scheduler.
interface fan_mode_scheduler_if;
  import fan_sched_pkg::*;

  logic             tick_1hz;
  logic             machine_state;
  logic             menu_btn;
  logic             mode1_btn;
  logic             mode2_btn;
  logic             mode3_btn;
  logic             mode_self_clean_btn;
  logic [2:0]       mode_state;
  logic [CNT_W-1:0] remain_sec;
  logic             menu_btn_state;
  logic             hurricane_used;
  logic             clean_remind;

  modport master (
    output tick_1hz, machine_state, menu_btn, mode1_btn, mode2_btn, mode3_btn,
           mode_self_clean_btn,
    input  mode_state, remain_sec, menu_btn_state, hurricane_used, clean_remind
  );

  modport slave (
    input  tick_1hz, machine_state, menu_btn, mode1_btn, mode2_btn, mode3_btn,
           mode_self_clean_btn,
    output mode_state, remain_sec, menu_btn_state, hurricane_used, clean_remind
  );

endinterface

// File: rtl/fan_mode_scheduler_sec_countdown.sv
// Loadable 8-bit seconds down-counter; done_o flags the tick that takes it from 1 to 0.
module sec_countdown
  import fan_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             tick_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Load priority is resolved by the caller, keeping done free of a path through load.
  assign done_o  = tick_i && (count_q == CNT_W'(1));
  assign count_o = count_q;

endmodule

// File: rtl/fan_mode_scheduler.sv
// Range-hood fan mode sequencer with timed hurricane, exit delay and self-clean states.
// Optional run-time cleaning reminder is built when FAN_SCHED_REMIND_EN is defined.
module fan_mode_scheduler
  import fan_sched_pkg::*;
#(
  parameter int unsigned HURRICANE_SEC = DEF_HURRICANE_SEC,
  parameter int unsigned EXIT_SEC      = DEF_EXIT_SEC,
  parameter int unsigned CLEAN_SEC     = DEF_CLEAN_SEC,
  parameter int unsigned REMIND_SEC    = DEF_REMIND_SEC
) (
  input logic                 clk,
  input logic                 rst,
  fan_mode_scheduler_if.slave bus
);

  if ((HURRICANE_SEC > 255) || (EXIT_SEC > 255) || (CLEAN_SEC > 255) ||
      (REMIND_SEC > 65535)) begin : g_cfg_check
    $error("fan_mode_scheduler: duration parameter out of range");
  end

  fan_state_e       state_q, state_d;
  logic             menu_q, menu_d;
  logic             hurr_q, hurr_d;
  logic             cd_load;
  logic [CNT_W-1:0] cd_val;
  logic [CNT_W-1:0] cd_count;
  logic             cd_done;

  sec_countdown u_countdown (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cd_load),
    .load_val_i (cd_val),
    .tick_i     (bus.tick_1hz),
    .count_o    (cd_count),
    .done_o     (cd_done)
  );

  always_comb begin
    state_d = state_q;
    menu_d  = menu_q;
    hurr_d  = hurr_q;
    cd_load = 1'b0;
    cd_val  = '0;
    if (!bus.machine_state) begin
      state_d = ST_STANDBY;
      menu_d  = 1'b0;
      hurr_d  = 1'b0;
      cd_load = 1'b1;
    end else begin
      case (state_q)
        ST_STANDBY: begin
          if (bus.menu_btn) begin
            menu_d = 1'b1;
          end else if (menu_q) begin
            if (bus.mode1_btn) begin
              state_d = ST_MODE1;
              menu_d  = 1'b0;
            end else if (bus.mode2_btn) begin
              state_d = ST_MODE2;
              menu_d  = 1'b0;
            end else if (bus.mode3_btn && !hurr_q) begin
              state_d = ST_MODE3;
              menu_d  = 1'b0;
              hurr_d  = 1'b1;
              cd_load = 1'b1;
              cd_val  = CNT_W'(HURRICANE_SEC);
            end else if (bus.mode_self_clean_btn) begin
              state_d = ST_SELF_CLEAN;
              menu_d  = 1'b0;
              cd_load = 1'b1;
              cd_val  = CNT_W'(CLEAN_SEC);
            end
          end
        end
        ST_MODE1, ST_MODE2: begin
          if (bus.menu_btn)       state_d = ST_STANDBY;
          else if (bus.mode1_btn) state_d = ST_MODE1;
          else if (bus.mode2_btn) state_d = ST_MODE2;
        end
        ST_MODE3: begin
          // Leaving by menu reloads the shared counter, overriding a same-cycle expiry.
          if (bus.menu_btn) begin
            state_d = ST_EXIT_DELAY;
            cd_load = 1'b1;
            cd_val  = CNT_W'(EXIT_SEC);
          end else if (cd_done) begin
            state_d = ST_MODE2;
          end
        end
        ST_EXIT_DELAY, ST_SELF_CLEAN: begin
          if (cd_done) state_d = ST_STANDBY;
        end
        default: begin
          state_d = ST_STANDBY;
          cd_load = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STANDBY;
      menu_q  <= 1'b0;
      hurr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      menu_q  <= menu_d;
      hurr_q  <= hurr_d;
    end
  end

`ifdef FAN_SCHED_REMIND_EN
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             remind_q, remind_d;
  logic             run_state;
  logic             clean_done;

  assign run_state  = state_q inside {ST_MODE1, ST_MODE2, ST_MODE3, ST_EXIT_DELAY};
  assign clean_done = bus.machine_state && (state_q == ST_SELF_CLEAN) && cd_done;

  always_comb begin
    acc_d = acc_q;
    if (clean_done) begin
      acc_d = '0;
    end else if (bus.machine_state && bus.tick_1hz && run_state && (acc_q != '1)) begin
      acc_d = acc_q + 1'b1;
    end
    remind_d = !clean_done && (32'(acc_d) >= REMIND_SEC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      remind_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      remind_q <= remind_d;
    end
  end

  assign bus.clean_remind = remind_q;
`else
  assign bus.clean_remind = 1'b0;
`endif

  assign bus.mode_state     = state_q;
  assign bus.remain_sec     = cd_count;
  assign bus.menu_btn_state = menu_q;
  assign bus.hurricane_used = hurr_q;

endmodule

// File: tb/tb_fan_mode_scheduler.sv
// Self-checking bench for fan_mode_scheduler: vector table, directed timed sequences, random vs model.
module tb_fan_mode_scheduler;

  localparam int HURR   = 60;
  localparam int EXITS  = 60;
  localparam int CLEAN  = 180;
  localparam int REMIND = 5;
`ifdef FAN_SCHED_REMIND_EN
  localparam bit REMIND_EN = 1'b1;
`else
  localparam bit REMIND_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fan_mode_scheduler_if bus ();

  fan_mode_scheduler #(
    .HURRICANE_SEC (HURR),
    .EXIT_SEC      (EXITS),
    .CLEAN_SEC     (CLEAN),
    .REMIND_SEC    (REMIND)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: modes 0..5 as in the mode_state encoding, times in whole seconds.
  typedef struct {
    int mode;
    int remain;
    bit menu;
    bit hurr;
    int acc;
    bit remind;
  } mdl_t;

  mdl_t mdl;

  function automatic mdl_t mdl_next(mdl_t s, bit pw, bit tk, bit mn, bit b1, bit b2, bit b3, bit bc);
    mdl_t n = s;
    if (!pw) begin
      n.mode = 0; n.remain = 0; n.menu = 0; n.hurr = 0;
      return n;
    end
    if (tk && (s.mode inside {1, 2, 3, 5}) && s.acc < 65535) n.acc = s.acc + 1;
    case (s.mode)
      0: begin
        if (mn) n.menu = 1;
        else if (s.menu) begin
          if (b1) begin n.mode = 1; n.menu = 0; end
          else if (b2) begin n.mode = 2; n.menu = 0; end
          else if (b3 && !s.hurr) begin n.mode = 3; n.remain = HURR; n.hurr = 1; n.menu = 0; end
          else if (bc) begin n.mode = 4; n.remain = CLEAN; n.menu = 0; end
        end
      end
      1, 2: begin
        if (mn) n.mode = 0;
        else if (b1) n.mode = 1;
        else if (b2) n.mode = 2;
      end
      3: begin
        if (mn) begin n.mode = 5; n.remain = EXITS; end
        else if (tk) begin
          n.remain = s.remain - 1;
          if (n.remain == 0) n.mode = 2;
        end
      end
      5: if (tk) begin
        n.remain = s.remain - 1;
        if (n.remain == 0) n.mode = 0;
      end
      4: if (tk) begin
        n.remain = s.remain - 1;
        if (n.remain == 0) begin n.mode = 0; n.acc = 0; end
      end
      default: n.mode = 0;
    endcase
    n.remind = REMIND_EN && (n.acc >= REMIND);
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input int m, input int r, input int mn, input int h, input int rm);
    chk({nm, ".mode"},   int'(bus.mode_state), m);
    chk({nm, ".remain"}, int'(bus.remain_sec), r);
    chk({nm, ".menu"},   int'(bus.menu_btn_state), mn);
    chk({nm, ".hurr"},   int'(bus.hurricane_used), h);
    chk({nm, ".remind"}, int'(bus.clean_remind), rm);
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later, advance the model.
  task automatic cycle(input bit pw, input bit tk, input bit mn, input bit b1, input bit b2,
                       input bit b3, input bit bc);
    bus.machine_state       = pw;
    bus.tick_1hz            = tk;
    bus.menu_btn            = mn;
    bus.mode1_btn           = b1;
    bus.mode2_btn           = b2;
    bus.mode3_btn           = b3;
    bus.mode_self_clean_btn = bc;
    @(posedge clk);
    #1;
    bus.tick_1hz            = 1'b0;
    bus.menu_btn            = 1'b0;
    bus.mode1_btn           = 1'b0;
    bus.mode2_btn           = 1'b0;
    bus.mode3_btn           = 1'b0;
    bus.mode_self_clean_btn = 1'b0;
    mdl = mdl_next(mdl, pw, tk, mn, b1, b2, b3, bc);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1, 1, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit pw, tk, mn, b1, b2, b3, bc;
    int mode, remain;
    bit menu, hurr;
  } vec_t;

  vec_t vt[20];

  initial begin
    mdl = '{0, 0, 0, 0, 0, 0};
    bus.machine_state = 0; bus.tick_1hz = 0; bus.menu_btn = 0; bus.mode1_btn = 0;
    bus.mode2_btn = 0; bus.mode3_btn = 0; bus.mode_self_clean_btn = 0;

    //         pw tk mn b1 b2 b3 bc  mode remain menu hurr
    vt[0]  = '{1, 0, 0, 0, 0, 0, 0,  0,   0,  0, 0};
    vt[1]  = '{1, 0, 0, 1, 0, 0, 0,  0,   0,  0, 0};
    vt[2]  = '{1, 0, 1, 0, 0, 0, 0,  0,   0,  1, 0};
    vt[3]  = '{1, 0, 1, 1, 0, 0, 0,  0,   0,  1, 0};
    vt[4]  = '{1, 0, 0, 1, 0, 0, 0,  1,   0,  0, 0};
    vt[5]  = '{1, 1, 0, 0, 1, 0, 0,  2,   0,  0, 0};
    vt[6]  = '{1, 0, 0, 0, 0, 1, 0,  2,   0,  0, 0};
    vt[7]  = '{1, 0, 0, 0, 0, 0, 1,  2,   0,  0, 0};
    vt[8]  = '{1, 0, 0, 1, 0, 0, 0,  1,   0,  0, 0};
    vt[9]  = '{1, 0, 1, 0, 0, 0, 0,  0,   0,  0, 0};
    vt[10] = '{1, 0, 1, 0, 0, 0, 0,  0,   0,  1, 0};
    vt[11] = '{1, 0, 0, 0, 0, 1, 0,  3,  60,  0, 1};
    vt[12] = '{1, 1, 0, 0, 0, 0, 0,  3,  59,  0, 1};
    vt[13] = '{1, 1, 1, 0, 0, 0, 0,  5,  60,  0, 1};
    vt[14] = '{1, 1, 0, 0, 0, 0, 0,  5,  59,  0, 1};
    vt[15] = '{1, 0, 0, 1, 0, 0, 0,  5,  59,  0, 1};
    vt[16] = '{0, 0, 0, 0, 0, 0, 0,  0,   0,  0, 0};
    vt[17] = '{1, 0, 1, 0, 0, 0, 0,  0,   0,  1, 0};
    vt[18] = '{1, 0, 0, 0, 0, 1, 0,  3,  60,  0, 1};
    vt[19] = '{0, 1, 0, 0, 0, 0, 0,  0,   0,  0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      cycle(vt[i].pw, vt[i].tk, vt[i].mn, vt[i].b1, vt[i].b2, vt[i].b3, vt[i].bc);
      chk($sformatf("vec%0d.mode", i),   int'(bus.mode_state),     vt[i].mode);
      chk($sformatf("vec%0d.remain", i), int'(bus.remain_sec),     vt[i].remain);
      chk($sformatf("vec%0d.menu", i),   int'(bus.menu_btn_state), int'(vt[i].menu));
      chk($sformatf("vec%0d.hurr", i),   int'(bus.hurricane_used), int'(vt[i].hurr));
    end

    // Full hurricane burst, then refusal of a second one until power cycles.
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0);
    chk_all("hurr_entry", 3, 60, 0, 1, 0);
    for (int k = 1; k <= 60; k++) begin
      cycle(1, 1, 0, 0, 0, 0, 0);
      if (k < 60) chk($sformatf("hurr_remain%0d", k), int'(bus.remain_sec), 60 - k);
    end
    chk_all("hurr_expire", 2, 0, 0, 1, int'(REMIND_EN));
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0);
    chk_all("hurr_reused", 0, 0, 1, 1, int'(REMIND_EN));
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0);
    chk_all("hurr_after_pwr", 3, 60, 0, 1, int'(REMIND_EN));

    // Menu mid-burst into exit delay.
    ticks(30);
    chk("hurr_mid", int'(bus.remain_sec), 30);
    cycle(1, 0, 1, 0, 0, 0, 0);
    chk_all("exit_entry", 5, 60, 0, 1, int'(REMIND_EN));
    ticks(59);
    chk_all("exit_last", 5, 1, 0, 1, int'(REMIND_EN));
    ticks(1);
    chk_all("exit_done", 0, 0, 0, 1, int'(REMIND_EN));

    // Self-clean aborted by power-off keeps the reminder; a full one clears it.
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1);
    chk_all("clean_entry", 4, 180, 0, 1, int'(REMIND_EN));
    ticks(99);
    chk("clean_mid", int'(bus.remain_sec), 81);
    cycle(0, 1, 0, 0, 0, 0, 0);
    chk_all("clean_abort", 0, 0, 0, 0, int'(REMIND_EN));
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 1);
    ticks(179);
    chk_all("clean_last", 4, 1, 0, 0, int'(REMIND_EN));
    ticks(1);
    chk_all("clean_done", 0, 0, 0, 0, 0);

    // Reminder threshold from MODE1 run time.
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      cycle(1, 1, 0, 0, 0, 0, 0);
      chk($sformatf("remind_tick%0d", k), int'(bus.clean_remind), (k >= 5) ? int'(REMIND_EN) : 0);
    end

    // Asynchronous reset in the middle of a countdown.
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    chk("pre_rst_remain", int'(bus.remain_sec), 59);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    mdl = '{0, 0, 0, 0, 0, 0};

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 9) == 0));
      chk_all("rand", mdl.mode, mdl.remain, int'(mdl.menu), int'(mdl.hurr), int'(mdl.remind));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
